// File: rtl/result_requant_drain.sv
// Result requantizer and row drain.
// Captures a final accumulator vector from the mesh and converts each row to a
// signed DW value (round-half-up, arithmetic shift, saturate). Rows are then
// streamed out one per cycle, row 0 first, over a valid/ready handshake.
module result_requant_drain #(
  parameter int ROWS    = 8,
  parameter int ACC_W   = 16,
  parameter int DW      = 8,
  parameter int ROW_W   = 3,
  parameter int SHIFT_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    res_valid,
  input  logic [ROWS*ACC_W-1:0]   result_flat,
  input  logic [SHIFT_W-1:0]      shift,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DW-1:0]           out_data,
  output logic [ROW_W-1:0]        out_row,
  output logic                    out_last,
  output logic                    busy,
  output logic                    overrun
);

  typedef enum logic {IDLE, DRAIN} state_t;

  localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'((2 ** (DW - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_LO = ~SAT_HI;

  // Add the half-LSB rounding constant and shift; one extra bit keeps the sum from wrapping.
  function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] a,
                                                        input logic [SHIFT_W-1:0] s_in);
    int s;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] sum;
    s = int'(s_in);
    if (s > ACC_W) s = ACC_W;
    rnd = '0;
    if (s != 0) rnd = (ACC_W+1)'(1) << (s - 1);
    sum = {a[ACC_W-1], a} + rnd;
    return sum >>> s;
  endfunction

  // Clip the shifted value into the signed DW output range.
  function automatic logic signed [DW-1:0] saturate(input logic signed [ACC_W:0] t);
    if (t > SAT_HI) return SAT_HI[DW-1:0];
    if (t < SAT_LO) return SAT_LO[DW-1:0];
    return t[DW-1:0];
  endfunction

  function automatic logic signed [DW-1:0] requant(input logic signed [ACC_W-1:0] a,
                                                   input logic [SHIFT_W-1:0] s_in);
    return saturate(round_shift(a, s_in));
  endfunction

  state_t                  state, next_state;
  logic signed [ACC_W-1:0] buf_p0 [ROWS];
  logic [SHIFT_W-1:0]      shift_p0;
  logic                    hs, last_hs, capture, advance, finish, drop;
  logic [ROW_W-1:0]        nxt_row;

  assign hs      = out_valid & out_ready;
  assign last_hs = hs & out_last;
  assign nxt_row = out_row + ROW_W'(1);
  assign busy    = (state == DRAIN);

  // Next-state and control decode.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        if (res_valid) begin
          capture    = 1'b1;
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (hs && !out_last) advance = 1'b1;
        if (last_hs) begin
          if (res_valid) capture = 1'b1;
          else begin
            finish     = 1'b1;
            next_state = IDLE;
          end
        end else if (res_valid) begin
          drop = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Stage p0: holding buffer, written only at capture so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < ROWS; i++) buf_p0[i] <= result_flat[i*ACC_W +: ACC_W];
      shift_p0 <= shift;
    end
  end

  // Stage p1: output row register; holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_last  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= drop;
      if (capture) begin
        out_valid <= 1'b1;
        out_data  <= requant(result_flat[ACC_W-1:0], shift);
        out_row   <= '0;
        out_last  <= (ROWS == 1);
      end else if (advance) begin
        out_data  <= requant(buf_p0[nxt_row], shift_p0);
        out_row   <= nxt_row;
        out_last  <= (nxt_row == ROW_W'(ROWS - 1));
      end else if (finish) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_result_requant_drain.sv
// Self-checking bench for result_requant_drain: scoreboard of expected rows,
// compared on every handshake observed at the falling edge.
module tb_result_requant_drain;

  localparam int ROWS = 8;
  localparam int ACC_W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         res_valid = 1'b0;
  logic [127:0] result_flat = '0;
  logic [3:0]   shift = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [7:0]   out_data;
  logic [2:0]   out_row;
  logic         out_last;
  logic         busy;
  logic         overrun;

  result_requant_drain dut (
    .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .result_flat(result_flat),
    .shift(shift), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_last(out_last), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] r;
    logic       l;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   ovr_cnt = 0;
  int   acc_v [ROWS];
  bit   stall_prev = 0;
  logic [7:0] prev_data;
  logic [2:0] prev_row;
  logic       prev_last;

  // Reference requant: exact floor division on wide integers, then clip.
  function automatic logic [7:0] model(input int a, input int s_in);
    longint s, v, p, q;
    s = (s_in > ACC_W) ? ACC_W : s_in;
    v = a + ((s == 0) ? 0 : (longint'(1) << (s - 1)));
    p = longint'(1) << s;
    if (v >= 0) q = v / p;
    else        q = -((-v + p - 1) / p);
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
    return q[7:0];
  endfunction

  function automatic logic [127:0] pack_acc();
    logic [127:0] p;
    p = '0;
    for (int r = 0; r < ROWS; r++) p[r*16 +: 16] = acc_v[r][15:0];
    return p;
  endfunction

  task automatic push_vec(input int sh);
    exp_t e;
    for (int r = 0; r < ROWS; r++) begin
      e.d = model(acc_v[r], sh);
      e.r = 3'(r);
      e.l = (r == ROWS - 1);
      exp_q.push_back(e);
    end
  endtask

  // One cycle, entered and left at a falling edge.
  task automatic step(input bit rdy, input bit rv, input int sh);
    exp_t e;
    out_ready = rdy;
    res_valid = rv;
    shift     = 4'(sh);
    result_flat = rv ? pack_acc() : {$urandom, $urandom, $urandom, $urandom};
    if (overrun === 1'b1) ovr_cnt++;
    if (stall_prev) begin
      checks++;
      if (out_data !== prev_data || out_row !== prev_row || out_last !== prev_last) begin
        errors++;
        $display("FAIL stall_hold: got data=%0d row=%0d last=%0d, need data=%0d row=%0d last=%0d",
                 out_data, out_row, out_last, prev_data, prev_row, prev_last);
      end
    end
    if (out_valid === 1'b1 && rdy) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_row: got row=%0d data=%0d, need no output", out_row, out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e.d || out_row !== e.r || out_last !== e.l) begin
          errors++;
          $display("FAIL row_out: got data=%0d row=%0d last=%0d, need data=%0d row=%0d last=%0d",
                   $signed(out_data), out_row, out_last, $signed(e.d), e.r, e.l);
        end
      end
    end
    stall_prev = (out_valid === 1'b1) && !rdy;
    prev_data = out_data;
    prev_row  = out_row;
    prev_last = out_last;
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic drain_all(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step(1'b1, 1'b0, 0);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d rows left, need 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_drain: got busy=%0b valid=%0b, need 0 0", busy, out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 0 || out_data !== 0 || out_row !== 0 || out_last !== 0 || busy !== 0 || overrun !== 0) begin
      errors++;
      $display("FAIL reset_state: got v=%0b d=%0d r=%0d l=%0b b=%0b o=%0b, need all 0",
               out_valid, out_data, out_row, out_last, busy, overrun);
    end
    rst_n = 1'b1;
    step(1'b1, 1'b0, 0);
    checks++;
    if (out_valid !== 0 || busy !== 0) begin
      errors++;
      $display("FAIL idle_after_reset: got v=%0b b=%0b, need 0 0", out_valid, busy);
    end
  endtask

  task automatic test_mesh_shift4();
    logic [7:0] tbl [ROWS] = '{8'd85, 8'd94, 8'd102, 8'd111, 8'd119, 8'd127, 8'd127, 8'd127};
    exp_t e;
    for (int r = 0; r < ROWS; r++) begin
      acc_v[r] = 1360 + 136 * r;
      e.d = tbl[r]; e.r = 3'(r); e.l = (r == ROWS - 1);
      exp_q.push_back(e);
    end
    step(1'b1, 1'b1, 4);
    for (int i = 0; i < ROWS; i++) begin
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL mesh_streaming: got v=%0b b=%0b at cycle %0d, need 1 1", out_valid, busy, i);
      end
      step(1'b1, 1'b0, 0);
    end
    drain_all(4);
  endtask

  task automatic test_saturation();
    for (int r = 0; r < ROWS; r++) acc_v[r] = 1360 + 136 * r;
    push_vec(0);
    step(1'b1, 1'b1, 0);
    drain_all(20);
    acc_v = '{-300, -2000, 0, 5, -6, 510, -514, 100};
    push_vec(2);
    step(1'b1, 1'b1, 2);
    drain_all(20);
    acc_v = '{-2000, 2000, -129, 128, -1, 1, 32767, -32768};
    push_vec(0);
    step(1'b1, 1'b1, 0);
    drain_all(20);
  endtask

  task automatic test_backpressure();
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int n;
    for (int r = 0; r < ROWS; r++) acc_v[r] = int'($urandom_range(0, 65535)) - 32768;
    push_vec(3);
    step(1'b0, 1'b1, 3);
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      step(pat[n % 4], 1'b0, 0);
      n++;
    end
    drain_all(4);
  endtask

  task automatic test_overrun();
    int base;
    base = ovr_cnt;
    for (int r = 0; r < ROWS; r++) acc_v[r] = 40 * r - 150;
    push_vec(1);
    step(1'b1, 1'b1, 1);
    repeat (3) step(1'b1, 1'b0, 0);
    for (int r = 0; r < ROWS; r++) acc_v[r] = 9999;
    step(1'b0, 1'b1, 5);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_pulse: got %0b, need 1", overrun);
    end
    drain_all(30);
    checks++;
    if (ovr_cnt - base != 1) begin
      errors++;
      $display("FAIL overrun_count: got %0d, need 1", ovr_cnt - base);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    base = ovr_cnt;
    for (int r = 0; r < ROWS; r++) acc_v[r] = 300 * r - 1000;
    push_vec(4);
    step(1'b1, 1'b1, 4);
    repeat (7) step(1'b1, 1'b0, 0);
    for (int r = 0; r < ROWS; r++) acc_v[r] = 77 * r + 3;
    push_vec(2);
    step(1'b1, 1'b1, 2);
    checks++;
    if (out_valid !== 1'b1 || out_row !== 3'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_no_bubble: got v=%0b row=%0d b=%0b, need 1 0 1", out_valid, out_row, busy);
    end
    drain_all(30);
    checks++;
    if (ovr_cnt - base != 0) begin
      errors++;
      $display("FAIL b2b_overrun: got %0d pulses, need 0", ovr_cnt - base);
    end
  endtask

  task automatic test_reset_mid_drain();
    for (int r = 0; r < ROWS; r++) acc_v[r] = 500 + r;
    push_vec(0);
    step(1'b1, 1'b1, 0);
    repeat (4) step(1'b1, 1'b0, 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 0 || out_data !== 0 || busy !== 0) begin
      errors++;
      $display("FAIL reset_mid_drain: got v=%0b d=%0d b=%0b, need 0 0 0", out_valid, out_data, busy);
    end
    exp_q.delete();
    stall_prev = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_release: got v=%0b b=%0b, need 0 0", out_valid, busy);
      end
      step(1'b1, 1'b0, 0);
    end
  endtask

  task automatic test_clamp();
    acc_v = '{32767, -32768, 0, 16384, -16385, 100, -100, 32766};
    push_vec(15);
    step(1'b1, 1'b1, 15);
    drain_all(20);
  endtask

  initial begin
    test_reset();
    test_mesh_shift4();
    test_saturation();
    test_backpressure();
    test_overrun();
    test_back_to_back();
    test_reset_mid_drain();
    test_clamp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, need finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/result_requant_drain.md
# result_requant_drain

Downstream stage of the mesh matrix-vector `top`. It captures the ROWS-wide `result_flat` accumulator vector when the controller flags it final, and requantizes each ACC_W accumulator to a signed DW value by arithmetic right shift, round-half-up and saturation. It then streams the rows out one per cycle, row 0 first, over a valid/ready handshake. The output feeds the next layer's x-vector packer or a write-back buffer.

## Interface
- `ROWS`, 8, number of mesh rows / result words
- `ACC_W`, 16, signed accumulator width per row
- `DW`, 8, signed output data width
- `ROW_W`, 3, log2(ROWS), width of row index
- `SHIFT_W`, 4, width of shift-amount input
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `res_valid`  in  1  one-cycle pulse: `result_flat` is final this cycle
- `result_flat`  in  ROWS*ACC_W  row i at bits [(i+1)*ACC_W-1 -: ACC_W], signed
- `shift`  in  SHIFT_W  right-shift amount, sampled with `res_valid`
- `out_valid`  out  1  `out_data` holds a valid row
- `out_ready`  in  1  consumer accepts the current row
- `out_data`  out  DW  requantized signed row value
- `out_row`  out  ROW_W  index of the row on `out_data`
- `out_last`  out  1  high with row ROWS-1
- `busy`  out  1  a vector is held or being drained
- `overrun`  out  1  one-cycle pulse: a `res_valid` was dropped

## Operation
- States: IDLE, DRAIN.
- Capture happens on a rising edge where `res_valid`=1 and either:
  - the block is in IDLE, or
  - the block is in DRAIN and the last row handshakes in the same cycle.
- At capture:
  - latch all ROWS accumulators and `shift` into the holding buffer
  - register the requant of row 0 onto `out_data`
  - set `out_row`=0 and `out_valid`=1; set `out_last`=1 only if ROWS=1
  - enter DRAIN
- In DRAIN:
  - A handshake (`out_valid & out_ready` at an edge) on row k<ROWS-1 loads the requant of row k+1 and sets `out_row`=k+1. `out_last` is set when k+1=ROWS-1.
  - A handshake on row ROWS-1 with no capture clears `out_valid` and `out_last` and returns to IDLE.
- `res_valid` in DRAIN without a last-row handshake: the vector is dropped, `overrun` pulses on the next cycle, and the buffer is untouched.
- Requant of signed accumulator a with shift s:
  - round = (s==0) ? 0 : 1<<(s-1)
  - t = (a + round) >>> s, computed at ACC_W+1 bits with no wrap
  - saturate t to [-2^(DW-1), 2^(DW-1)-1]
- Shift values s ≥ ACC_W are clamped to ACC_W.
- `busy` = (state==DRAIN).

## Timing
- Reset (async assert, sync-released by design): state IDLE, `out_valid`=0, `out_data`=0, `out_row`=0, `out_last`=0, `busy`=0, `overrun`=0, buffer contents don't-care.
- Reset mid-drain discards the vector; no partial rows are emitted after release.
- Latency: `res_valid` at edge N gives `out_valid`=1 with row 0 after edge N.
- Throughput: 1 row/cycle with `out_ready` held high, so ROWS cycles per vector. With back-to-back capture on the last handshake there are zero bubbles.
- While `out_valid`=1 and `out_ready`=0, `out_data`, `out_row` and `out_last` hold stable.
- `out_valid` never deasserts without a handshake, except on reset.
- `out_ready` is ignored when `out_valid`=0.
- The `result_flat` and `shift` values are sampled only at the capture edge; later changes on those inputs have no effect.

## Test plan
- Mesh vector from weights w[r][c]=r+c and x[c]=c+1 (COLS=16) gives accumulators 1360+136r. With `shift`=4 and `out_ready`=1, rows 0..7 give 85,94,102,111,119,127,127,127 in consecutive cycles. `out_last` is high only on row 7, and `busy` drops after the row-7 handshake.
- Same vector, `shift`=0: all rows give 127 (positive saturation). Accumulators -300 (shift 2) give -75; -2000 (shift 0) gives -128.
- Backpressure: drive `out_ready` with pattern 1,0,0,1,... during a drain. Each row holds stable while stalled; all 8 rows are emitted in order with none lost or duplicated.
- Second `res_valid` at row 3 of a drain: `overrun` pulses once, and the original 8 rows complete unchanged. A second `res_valid` coincident with the row-7 handshake: the new row 0 appears the next cycle with no bubble and no `overrun`.
- Assert `rst_n`=0 at row 4 of a drain: `out_valid`, `out_data` and `busy` go to 0 immediately. After release, the outputs stay idle until the next `res_valid`.
- `shift`=15 (clamped path) with accumulator 32767 gives 1; with -32768 it gives -1.
